// File: rtl/sc_pointsdisplay.sv
// Frogger score display: converts the 6-bit points value to two BCD digits with a
// sequential double-dabble engine and drives two active-low seven-segment displays.
module sc_pointsdisplay #(
   parameter logic BLANK_LEADING_ZERO = 1'b1
) (
   input  logic       SC_POINTSDISPLAY_CLOCK_50,
   input  logic       SC_POINTSDISPLAY_RESET_InHigh,
   input  logic [5:0] SC_POINTSDISPLAY_Points_InBus,
   output logic [6:0] SC_POINTSDISPLAY_Tens7Seg_OutBus,
   output logic [6:0] SC_POINTSDISPLAY_Units7Seg_OutBus,
   output logic [3:0] SC_POINTSDISPLAY_TensBCD_OutBus,
   output logic [3:0] SC_POINTSDISPLAY_UnitsBCD_OutBus,
   output logic       SC_POINTSDISPLAY_Busy_OutHigh,
   output logic       SC_POINTSDISPLAY_Update_OutHigh
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
   localparam logic [1:0] ST_UPDATE = 2'd2;

   localparam logic [6:0] SEG_BLANK    = 7'b1111111;
   localparam logic [6:0] SEG_ZERO     = 7'b1000000;
   localparam logic [6:0] TENS_SEG_RST = BLANK_LEADING_ZERO ? SEG_BLANK : SEG_ZERO;

   function automatic logic [3:0] add3(input logic [3:0] n);
      if (n >= 4'd5) begin
         return n + 4'd3;
      end else begin
         return n;
      end
   endfunction

   // Active-low gfedcba; non-decimal nibbles fall through to blank.
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return SEG_BLANK;
      endcase
   endfunction

   logic [1:0]  state_q, state_d;
   logic [5:0]  last_q, last_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [13:0] shift_q, shift_d;
   logic [3:0]  tens_bcd_q, tens_bcd_d, units_bcd_q, units_bcd_d;
   logic [6:0]  tens_seg_q, tens_seg_d, units_seg_q, units_seg_d;
   logic        busy_q, busy_d, update_q, update_d;
   logic [13:0] adj_s;

   // Next-state logic for the conversion FSM and all registered outputs.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      tens_bcd_d  = tens_bcd_q;
      units_bcd_d = units_bcd_q;
      tens_seg_d  = tens_seg_q;
      units_seg_d = units_seg_q;
      adj_s       = {add3(shift_q[13:10]), add3(shift_q[9:6]), shift_q[5:0]};
      case (state_q)
         ST_IDLE: begin
            if (SC_POINTSDISPLAY_Points_InBus != last_q) begin
               shift_d = {8'd0, SC_POINTSDISPLAY_Points_InBus};
               last_d  = SC_POINTSDISPLAY_Points_InBus;
               cnt_d   = 3'd0;
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            shift_d = {adj_s[12:0], 1'b0};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd5) begin
               state_d = ST_UPDATE;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_UPDATE: begin
            tens_bcd_d  = shift_q[13:10];
            units_bcd_d = shift_q[9:6];
            units_seg_d = seg_decode(shift_q[9:6]);
            if (BLANK_LEADING_ZERO && (shift_q[13:10] == 4'd0)) begin
               tens_seg_d = SEG_BLANK;
            end else begin
               tens_seg_d = seg_decode(shift_q[13:10]);
            end
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d   = (state_d != ST_IDLE);
      update_d = (state_q == ST_UPDATE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge SC_POINTSDISPLAY_CLOCK_50) begin
      if (SC_POINTSDISPLAY_RESET_InHigh) begin
         state_q     <= ST_IDLE;
         last_q      <= 6'd0;
         cnt_q       <= 3'd0;
         shift_q     <= 14'd0;
         tens_bcd_q  <= 4'd0;
         units_bcd_q <= 4'd0;
         tens_seg_q  <= TENS_SEG_RST;
         units_seg_q <= SEG_ZERO;
         busy_q      <= 1'b0;
         update_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         tens_bcd_q  <= tens_bcd_d;
         units_bcd_q <= units_bcd_d;
         tens_seg_q  <= tens_seg_d;
         units_seg_q <= units_seg_d;
         busy_q      <= busy_d;
         update_q    <= update_d;
      end
   end

   assign SC_POINTSDISPLAY_Tens7Seg_OutBus  = tens_seg_q;
   assign SC_POINTSDISPLAY_Units7Seg_OutBus = units_seg_q;
   assign SC_POINTSDISPLAY_TensBCD_OutBus   = tens_bcd_q;
   assign SC_POINTSDISPLAY_UnitsBCD_OutBus  = units_bcd_q;
   assign SC_POINTSDISPLAY_Busy_OutHigh     = busy_q;
   assign SC_POINTSDISPLAY_Update_OutHigh   = update_q;

endmodule

// File: tb/tb_sc_pointsdisplay.sv
// Directed bench for sc_pointsdisplay; a second instance covers BLANK_LEADING_ZERO=0.
module tb_sc_pointsdisplay;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [5:0] pts = 6'd0;
   logic [6:0] tens_seg, units_seg, nb_tens_seg, nb_units_seg;
   logic [3:0] tens_bcd, units_bcd, nb_tens_bcd, nb_units_bcd;
   logic       busy, upd, nb_busy, nb_upd;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   sc_pointsdisplay dut (
      .SC_POINTSDISPLAY_CLOCK_50        (clk),
      .SC_POINTSDISPLAY_RESET_InHigh    (rst),
      .SC_POINTSDISPLAY_Points_InBus    (pts),
      .SC_POINTSDISPLAY_Tens7Seg_OutBus (tens_seg),
      .SC_POINTSDISPLAY_Units7Seg_OutBus(units_seg),
      .SC_POINTSDISPLAY_TensBCD_OutBus  (tens_bcd),
      .SC_POINTSDISPLAY_UnitsBCD_OutBus (units_bcd),
      .SC_POINTSDISPLAY_Busy_OutHigh    (busy),
      .SC_POINTSDISPLAY_Update_OutHigh  (upd)
   );

   sc_pointsdisplay #(.BLANK_LEADING_ZERO(1'b0)) dut_nb (
      .SC_POINTSDISPLAY_CLOCK_50        (clk),
      .SC_POINTSDISPLAY_RESET_InHigh    (rst),
      .SC_POINTSDISPLAY_Points_InBus    (pts),
      .SC_POINTSDISPLAY_Tens7Seg_OutBus (nb_tens_seg),
      .SC_POINTSDISPLAY_Units7Seg_OutBus(nb_units_seg),
      .SC_POINTSDISPLAY_TensBCD_OutBus  (nb_tens_bcd),
      .SC_POINTSDISPLAY_UnitsBCD_OutBus (nb_units_bcd),
      .SC_POINTSDISPLAY_Busy_OutHigh    (nb_busy),
      .SC_POINTSDISPLAY_Update_OutHigh  (nb_upd)
   );

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock edge; outputs are then read 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Apply a new value and step E0..E7, checking Busy span and the displayed digits.
   task automatic conv(input logic [5:0] p, input logic [3:0] t, input logic [3:0] u,
                       input logic [6:0] ts, input logic [6:0] us, input logic [6:0] nb_ts);
      int nbusy = 0;
      int nupd  = 0;
      pts = p;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (busy) nbusy++;
         if (upd) nupd++;
      end
      check_eq("busy_cycles", 16'(nbusy), 16'd7);
      check_eq("update_count", 16'(nupd), 16'd1);
      check_eq("update_at_e7", {15'd0, upd}, 16'd1);
      check_eq("tens_bcd", {12'd0, tens_bcd}, {12'd0, t});
      check_eq("units_bcd", {12'd0, units_bcd}, {12'd0, u});
      check_eq("tens_seg", {9'd0, tens_seg}, {9'd0, ts});
      check_eq("units_seg", {9'd0, units_seg}, {9'd0, us});
      check_eq("nb_tens_seg", {9'd0, nb_tens_seg}, {9'd0, nb_ts});
      check_eq("nb_units_seg", {9'd0, nb_units_seg}, {9'd0, us});
      tick();
      check_eq("update_drop", {15'd0, upd}, 16'd0);
      check_eq("idle_busy", {15'd0, busy}, 16'd0);
   endtask

   initial begin
      int cnt;
      #1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("rst_tens_seg", {9'd0, tens_seg}, 16'h007F);
      check_eq("rst_units_seg", {9'd0, units_seg}, 16'h0040);
      check_eq("rst_nb_tens_seg", {9'd0, nb_tens_seg}, 16'h0040);
      check_eq("rst_bcd", {8'd0, tens_bcd, units_bcd}, 16'd0);
      check_eq("rst_busy_upd", {14'd0, busy, upd}, 16'd0);

      // Points held at 0: nothing should ever start.
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (busy || upd || nb_busy || nb_upd) cnt++;
      end
      check_eq("quiet_after_reset", 16'(cnt), 16'd0);

      conv(6'd37, 4'd3, 4'd7, 7'b0110000, 7'b1111000, 7'b0110000);
      conv(6'd63, 4'd6, 4'd3, 7'b0000010, 7'b0110000, 7'b0000010);
      conv(6'd5,  4'd0, 4'd5, 7'b1111111, 7'b0010010, 7'b1000000);
      conv(6'd10, 4'd1, 4'd0, 7'b1111001, 7'b1000000, 7'b1111001);
      conv(6'd5,  4'd0, 4'd5, 7'b1111111, 7'b0010010, 7'b1000000);

      // 37 then 12 arriving mid-conversion: both shown, in order.
      cnt = 0;
      pts = 6'd37;
      for (int e = 0; e <= 15; e++) begin
         tick();
         if (upd) cnt++;
         if (e == 2) pts = 6'd12;
         if (e == 7) begin
            check_eq("chg_first_tens", {12'd0, tens_bcd}, 16'd3);
            check_eq("chg_first_units", {12'd0, units_bcd}, 16'd7);
            check_eq("chg_first_busy", {15'd0, busy}, 16'd0);
         end
         if (e == 8) check_eq("chg_reload_busy", {15'd0, busy}, 16'd1);
         if (e == 14) check_eq("chg_no_early_upd", {15'd0, upd}, 16'd0);
      end
      check_eq("chg_second_tens_seg", {9'd0, tens_seg}, {9'd0, 7'b1111001});
      check_eq("chg_second_units_seg", {9'd0, units_seg}, {9'd0, 7'b0100100});
      check_eq("chg_second_bcd", {8'd0, tens_bcd, units_bcd}, 16'h0012);
      check_eq("chg_update_count", 16'(cnt), 16'd2);

      // Reset at E3 of a 45 conversion, then the conversion restarts.
      pts = 6'd45;
      for (int e = 0; e < 3; e++) tick();
      check_eq("pre_rst_busy", {15'd0, busy}, 16'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("mid_rst_busy", {15'd0, busy}, 16'd0);
      check_eq("mid_rst_bcd", {8'd0, tens_bcd, units_bcd}, 16'd0);
      check_eq("mid_rst_tens_seg", {9'd0, tens_seg}, 16'h007F);
      check_eq("mid_rst_units_seg", {9'd0, units_seg}, 16'h0040);
      cnt = 0;
      for (int e = 4; e <= 11; e++) begin
         tick();
         if (busy) cnt++;
      end
      check_eq("restart_busy_cycles", 16'(cnt), 16'd7);
      check_eq("restart_update", {15'd0, upd}, 16'd1);
      check_eq("restart_bcd", {8'd0, tens_bcd, units_bcd}, 16'h0045);
      check_eq("restart_tens_seg", {9'd0, tens_seg}, {9'd0, 7'b0011001});
      check_eq("restart_units_seg", {9'd0, units_seg}, {9'd0, 7'b0010010});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sc_pointsdisplay.md
# sc_pointsdisplay

Score display stage for the Frogger datapath. Consumes the 6-bit registered points value produced by the points counter, converts it to two BCD digits with a sequential shift-add-3 (double-dabble) engine, and drives two active-low seven-segment displays. A conversion starts only when the points value differs from the last converted value. Outputs hold their value between conversions.

## Interface
- BLANK_LEADING_ZERO, default 1: 1 blanks the tens display when the tens digit is 0; 0 shows "0".
- SC_POINTSDISPLAY_CLOCK_50  in  1  system clock, 50 MHz.
- SC_POINTSDISPLAY_RESET_InHigh  in  1  reset; one clock; reset is synchronous and active-high.
- SC_POINTSDISPLAY_Points_InBus  in  6  binary points, 0–63, from the points counter.
- SC_POINTSDISPLAY_Tens7Seg_OutBus  out  7  tens segments, active-low, bit0=a … bit6=g.
- SC_POINTSDISPLAY_Units7Seg_OutBus  out  7  units segments, same encoding.
- SC_POINTSDISPLAY_TensBCD_OutBus  out  4  tens digit, binary-coded decimal.
- SC_POINTSDISPLAY_UnitsBCD_OutBus  out  4  units digit, binary-coded decimal.
- SC_POINTSDISPLAY_Busy_OutHigh  out  1  high while a conversion is in progress.
- SC_POINTSDISPLAY_Update_OutHigh  out  1  one-cycle pulse when outputs take a new value.

## Operation
- FSM states: IDLE, SHIFT, UPDATE. Registered state; all outputs are registered.
- IDLE: if Points_InBus != LastValue, then at the next edge:
  - load the 14-bit shift register = {8'b0, Points_InBus};
  - set LastValue = Points_InBus;
  - clear the 3-bit iteration counter;
  - go to SHIFT.
  - Otherwise remain in IDLE.
- SHIFT: each edge performs one iteration.
  - Add-3 step: for each BCD nibble (bits [13:10], [9:6]) that is ≥5, add 3.
  - Then shift the whole register left by 1 and increment the counter.
  - After the 6th iteration, go to UPDATE.
- UPDATE: at the next edge:
  - load TensBCD = shift[13:10] and UnitsBCD = shift[9:6];
  - load both 7-seg registers from the decoded digits;
  - pulse Update_OutHigh for one cycle;
  - go to IDLE.
- Seg decode (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Blank=1111111.
- Tens blanking applies only when BLANK_LEADING_ZERO=1 and TensBCD=0. Units is never blanked.
- Busy_OutHigh = (state != IDLE).
- Width rules:
  - Tens digit is always ≤6.
  - Nibble values 10–15 cannot occur; the decoder maps them to blank.

## Timing
- Input change visible before edge E0 (FSM in IDLE):
  - E0: load; Busy goes high.
  - E1–E6: six iterations.
  - E6: state becomes UPDATE.
  - E7: outputs update, Update_OutHigh high for one cycle, state becomes IDLE, Busy goes low.
  - Latency: 7 clocks from E0.
- Input changes while Busy: ignored for the current conversion. The next IDLE cycle compares against LastValue and starts a new conversion at the following edge. The final stable input is therefore always displayed.
- Back-to-back conversions: IDLE lasts at least one cycle between conversions. Minimum period is 8 clocks.
- Reset values (at the edge where RESET_InHigh=1):
  - state IDLE, LastValue 0, counter 0, shift register 0;
  - TensBCD 0, UnitsBCD 0;
  - Units7Seg 1000000;
  - Tens7Seg 1111111 if BLANK_LEADING_ZERO=1, else 1000000;
  - Busy 0, Update 0.
- Reset mid-conversion: the conversion is abandoned and all of the above take effect at that edge. If Points_InBus ≠ 0 after reset, a new conversion starts at the first IDLE edge.
- Points_InBus = 0 right after reset: no conversion, no Update pulse.

## Test plan
- Reset with Points=0, hold 20 cycles:
  - Tens7Seg=1111111, Units7Seg=1000000, BCD 0/0;
  - Busy and Update never assert.
- Points 0→37:
  - Busy high for exactly 7 cycles;
  - at E7: TensBCD=3, UnitsBCD=7, Tens7Seg=0110000, Units7Seg=1111000, one Update pulse.
- Points=63:
  - TensBCD=6, UnitsBCD=3;
  - Tens7Seg=0000010, Units7Seg=0110000.
- Points 37, then 12 at E3:
  - 37 is displayed at E7;
  - the second conversion loads at E8;
  - 12 is displayed at E15 (1111001 / 0100100);
  - exactly two Update pulses.
- Points=5:
  - BLANK_LEADING_ZERO=1 gives Tens7Seg=1111111;
  - BLANK_LEADING_ZERO=0 gives Tens7Seg=1000000;
  - Units7Seg=0010010 in both cases.
- Points 0→45, assert reset at E3 for one cycle while Points stays 45:
  - at E3, outputs take reset values and Busy=0;
  - a conversion restarts at the next edge;
  - 4/5 is displayed 7 clocks after that.
